hazard_ctrl_fsm: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage MIPS core. It replaces the purely combinational forwarding, hazard and branch-flush logic with a registered state machine. The state machine adds multi-cycle load-use stalls, multi-slot branch flush, a data-memory wait freeze and a saturating stall-cycle counter. It sits beside the main decoder and drives the PC, IF/ID, ID/EX bubble mux and the EX forwarding muxes.

---
 rtl/hazard_ctrl_fsm.sv | 178 +++++++++++++++++
 tb/tb_hazard_ctrl_fsm.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_fsm
// Description : Registered hazard controller for the 5-stage MIPS pipeline:
//               EX forwarding, multi-cycle load-use stall, multi-slot branch
//               flush, data-memory wait freeze and a stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_fsm #(
    parameter int REG_AW      = 5,
    parameter int LOAD_STALL  = 1,
    parameter int FLUSH_SLOTS = 1,
    parameter int CNT_W       = 3,
    parameter int PERF_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              id_ex_mem_read,
    input  logic [REG_AW-1:0] id_ex_rs,
    input  logic [REG_AW-1:0] id_ex_rt,
    input  logic              ex_mem_reg_write,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              mem_wb_reg_write,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_flush,
    output logic              id_ex_bubble,
    output logic              stage_hold,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FLUSH  = 2'd2,
        MWAIT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  c_LOAD_RELOAD  = CNT_W'(LOAD_STALL - 1);
    localparam logic [CNT_W-1:0]  c_FLUSH_RELOAD = CNT_W'(FLUSH_SLOTS - 1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE      = CNT_W'(1);
    localparam logic [PERF_W-1:0] c_PERF_MAX     = '1;
    localparam logic [REG_AW-1:0] c_REG_ZERO     = '0;

    state_t              r_state;
    state_t              r_retState;
    logic [CNT_W-1:0]    r_cnt;
    logic [PERF_W-1:0]   r_stallCycles;

    state_t              w_nextState;
    state_t              w_nextRet;
    state_t              w_effState;
    logic [CNT_W-1:0]    w_nextCnt;
    logic                w_hz;
    logic                w_pcWrite;
    logic                w_ifIdWrite;
    logic                w_ifFlush;
    logic                w_idExBubble;
    logic                w_stageHold;
    logic [1:0]          w_fwdA;
    logic [1:0]          w_fwdB;

    // EX/MEM result is newer than MEM/WB, so it wins when both match.
    function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] src);
        if (ex_mem_reg_write && (ex_mem_rd != c_REG_ZERO) && (ex_mem_rd == src))
            return 2'b10;
        else if (mem_wb_reg_write && (mem_wb_rd != c_REG_ZERO) && (mem_wb_rd == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign w_hz = id_ex_mem_read && (id_ex_rt != c_REG_ZERO) &&
                  ((id_ex_rt == id_rs) || (id_uses_rt && (id_ex_rt == id_rt)));

    // Once memory is ready again, the waiting cycle acts as the interrupted state.
    assign w_effState = ((r_state == MWAIT) && !mem_busy) ? r_retState : r_state;

    always_comb begin
        w_nextState  = w_effState;
        w_nextRet    = r_retState;
        w_nextCnt    = r_cnt;
        w_pcWrite    = 1'b1;
        w_ifIdWrite  = 1'b1;
        w_ifFlush    = 1'b0;
        w_idExBubble = 1'b0;
        w_stageHold  = 1'b0;
        w_fwdA       = fwdSel(id_ex_rs);
        w_fwdB       = fwdSel(id_ex_rt);

        if (rst) begin
            w_pcWrite    = 1'b0;
            w_ifIdWrite  = 1'b0;
            w_ifFlush    = 1'b1;
            w_idExBubble = 1'b1;
            w_fwdA       = 2'b00;
            w_fwdB       = 2'b00;
            w_nextState  = RUN;
            w_nextRet    = RUN;
            w_nextCnt    = '0;
        end else if (mem_busy) begin
            w_pcWrite   = 1'b0;
            w_ifIdWrite = 1'b0;
            w_stageHold = 1'b1;
            w_nextState = MWAIT;
            if (r_state != MWAIT)
                w_nextRet = r_state;
        end else begin
            case (w_effState)
                LSTALL: begin
                    w_pcWrite    = 1'b0;
                    w_ifIdWrite  = 1'b0;
                    w_idExBubble = 1'b1;
                    w_nextCnt    = r_cnt - c_CNT_ONE;
                    w_nextState  = (r_cnt <= c_CNT_ONE) ? RUN : LSTALL;
                end
                FLUSH: begin
                    w_ifFlush   = 1'b1;
                    w_nextCnt   = r_cnt - c_CNT_ONE;
                    w_nextState = (r_cnt <= c_CNT_ONE) ? RUN : FLUSH;
                end
                default: begin
                    w_nextState = RUN;
                    if (w_hz) begin
                        w_pcWrite    = 1'b0;
                        w_ifIdWrite  = 1'b0;
                        w_idExBubble = 1'b1;
                        if (LOAD_STALL > 1) begin
                            w_nextState = LSTALL;
                            w_nextCnt   = c_LOAD_RELOAD;
                        end
                    end else if (branch_taken || jump) begin
                        w_ifFlush = 1'b1;
                        if (FLUSH_SLOTS > 1) begin
                            w_nextState = FLUSH;
                            w_nextCnt   = c_FLUSH_RELOAD;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_retState    <= RUN;
            r_cnt         <= '0;
            r_stallCycles <= '0;
        end else begin
            r_state    <= w_nextState;
            r_retState <= w_nextRet;
            r_cnt      <= w_nextCnt;
            if (!w_pcWrite && (r_stallCycles != c_PERF_MAX))
                r_stallCycles <= r_stallCycles + 1'b1;
        end
    end

    assign pc_write     = w_pcWrite;
    assign if_id_write  = w_ifIdWrite;
    assign if_flush     = w_ifFlush;
    assign id_ex_bubble = w_idExBubble;
    assign stage_hold   = w_stageHold;
    assign forward_a    = w_fwdA;
    assign forward_b    = w_fwdB;
    assign stall_cycles = r_stallCycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_fsm.sv
`default_nettype none
// Testbench for hazard_ctrl_fsm: directed scenarios plus random traffic,
// all checked against a remaining-cycles reference model.
module tb_hazard_ctrl_fsm;

    localparam int LS = 3;
    localparam int FS = 2;
    localparam int PW = 4;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] id_rs, id_rt, id_ex_rs, id_ex_rt, ex_mem_rd, mem_wb_rd;
    logic          id_uses_rt, id_ex_mem_read, ex_mem_reg_write, mem_wb_reg_write;
    logic          branch_taken, jump, mem_busy;
    logic          pc_write, if_id_write, if_flush, id_ex_bubble, stage_hold;
    logic [1:0]    forward_a, forward_b;
    logic [PW-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    // Model: outstanding stall / flush cycles; a memory wait simply pauses them.
    int stallLeft = 0;
    int flushLeft = 0;
    int perf      = 0;

    hazard_ctrl_fsm #(
        .REG_AW(AW), .LOAD_STALL(LS), .FLUSH_SLOTS(FS), .CNT_W(3), .PERF_W(PW)
    ) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt),
        .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_rd(ex_mem_rd),
        .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd),
        .branch_taken(branch_taken), .jump(jump), .mem_busy(mem_busy),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_flush(if_flush),
        .id_ex_bubble(id_ex_bubble), .stage_hold(stage_hold),
        .forward_a(forward_a), .forward_b(forward_b), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] fwd(input logic [AW-1:0] src);
        if (ex_mem_reg_write && ex_mem_rd != 0 && ex_mem_rd == src) return 2'b10;
        if (mem_wb_reg_write && mem_wb_rd != 0 && mem_wb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle();
        rst = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_ex_mem_read = 1'b0;
        id_ex_rs = '0; id_ex_rt = '0; ex_mem_reg_write = 1'b0; ex_mem_rd = '0;
        mem_wb_reg_write = 1'b0; mem_wb_rd = '0; branch_taken = 1'b0; jump = 1'b0;
        mem_busy = 1'b0;
    endtask

    // Samples the DUT at negedge, produces the model expectation, advances the model.
    // Vector: {pc_write, if_id_write, if_flush, id_ex_bubble, stage_hold, fa, fb, stall}
    task automatic tick(output logic [12:0] o, output logic [12:0] e);
        logic hz;
        logic [4:0] c;
        logic [1:0] fa, fb;
        @(negedge clk);
        o = {pc_write, if_id_write, if_flush, id_ex_bubble, stage_hold,
             forward_a, forward_b, stall_cycles};
        hz = id_ex_mem_read && id_ex_rt != 0 &&
             (id_ex_rt == id_rs || (id_uses_rt && id_ex_rt == id_rt));
        fa = fwd(id_ex_rs);
        fb = fwd(id_ex_rt);
        if (rst) begin
            c = 5'b00110; fa = 2'b00; fb = 2'b00;
        end else if (mem_busy) begin
            c = 5'b00001;
        end else if (stallLeft > 0) begin
            c = 5'b00010; stallLeft--;
        end else if (flushLeft > 0) begin
            c = 5'b11100; flushLeft--;
        end else if (hz) begin
            c = 5'b00010; stallLeft = LS - 1;
        end else if (branch_taken || jump) begin
            c = 5'b11100; flushLeft = FS - 1;
        end else begin
            c = 5'b11000;
        end
        e = {c, fa, fb, 4'(perf)};
        if (rst) begin
            perf = 0; stallLeft = 0; flushLeft = 0;
        end else if (!c[4] && perf < (1 << PW) - 1) begin
            perf++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        logic [12:0] o, e;
        idle();
        rst = 1'b1;
        tick(o, e);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] o, e;
        idle();
        rst = 1'b1;
        tick(o, e);
        tick(o, e);
        checks++;
        if (o !== e || o[12:4] !== 9'b001100000) begin
            errors++; $display("FAIL reset_outputs: got %b want %b", o, e);
        end
        rst = 1'b0;
        tick(o, e);
        checks++;
        if (o !== e || o[12] !== 1'b1 || o[3:0] !== 4'd0) begin
            errors++; $display("FAIL reset_release: got %b want %b", o, e);
        end
    endtask

    task automatic test_forwarding();
        logic [12:0] o, e;
        doReset();
        ex_mem_reg_write = 1'b1; ex_mem_rd = 5'd3;
        mem_wb_reg_write = 1'b1; mem_wb_rd = 5'd3; id_ex_rs = 5'd3;
        tick(o, e);
        checks++;
        if (o !== e || o[7:6] !== 2'b10) begin
            errors++; $display("FAIL fwd_exmem_priority: got %b want %b", o, e);
        end
        ex_mem_rd = 5'd0; mem_wb_rd = 5'd0;
        tick(o, e);
        checks++;
        if (o !== e || o[7:6] !== 2'b00) begin
            errors++; $display("FAIL fwd_r0: got %b want %b", o, e);
        end
        ex_mem_reg_write = 1'b0; mem_wb_rd = 5'd3; id_ex_rt = 5'd3;
        tick(o, e);
        checks++;
        if (o !== e || o[7:6] !== 2'b01 || o[5:4] !== 2'b01) begin
            errors++; $display("FAIL fwd_memwb: got %b want %b", o, e);
        end
        for (int i = 0; i < 40; i++) begin
            ex_mem_reg_write = 1'($urandom); mem_wb_reg_write = 1'($urandom);
            ex_mem_rd = 5'($urandom_range(0, 3)); mem_wb_rd = 5'($urandom_range(0, 3));
            id_ex_rs = 5'($urandom_range(0, 3)); id_ex_rt = 5'($urandom_range(0, 3));
            tick(o, e);
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL fwd_random: got %b want %b", o, e);
            end
        end
    endtask

    task automatic test_load_stall();
        logic [12:0] o, e;
        int nStall = 0;
        doReset();
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; id_rs = 5'd5;
        for (int i = 0; i < 6; i++) begin
            tick(o, e);
            if (i == 0) idle();
            if (o[12] === 1'b0 && o[9] === 1'b1) nStall++;
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL load_stall_cycle%0d: got %b want %b", i, o, e);
            end
        end
        checks++;
        if (nStall != LS || o[3:0] !== 4'd3) begin
            errors++; $display("FAIL load_stall_len: got %0d/%0d want 3/3", nStall, o[3:0]);
        end
    endtask

    task automatic test_flush();
        logic [12:0] o, e;
        int nFlush = 0;
        doReset();
        branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(o, e);
            if (i == 1) branch_taken = 1'b0;
            if (o[10] === 1'b1 && o[12] === 1'b1) nFlush++;
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL flush_cycle%0d: got %b want %b", i, o, e);
            end
        end
        checks++;
        if (nFlush != FS) begin
            errors++; $display("FAIL flush_len: got %0d want %0d", nFlush, FS);
        end
    endtask

    task automatic test_mem_wait();
        logic [12:0] o, e;
        int nHold = 0, nStall = 0, nBub = 0;
        doReset();
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; id_rs = 5'd5;
        for (int i = 0; i < 10; i++) begin
            tick(o, e);
            idle();
            mem_busy = (i >= 0 && i < 4);
            if (o[8] === 1'b1) nHold++;
            if (o[12] === 1'b0) nStall++;
            if (o[9] === 1'b1) nBub++;
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL mem_wait_cycle%0d: got %b want %b", i, o, e);
            end
        end
        checks++;
        if (nHold != 4 || nStall != 7 || nBub != 3 || o[3:0] !== 4'd7) begin
            errors++;
            $display("FAIL mem_wait_counts: got hold=%0d stall=%0d bub=%0d cnt=%0d want 4/7/3/7",
                     nHold, nStall, nBub, o[3:0]);
        end
    endtask

    task automatic test_reset_mid_flush();
        logic [12:0] o, e;
        doReset();
        branch_taken = 1'b1;
        tick(o, e);
        branch_taken = 1'b0; rst = 1'b1;
        tick(o, e);
        checks++;
        if (o !== e || o[12:4] !== 9'b001100000) begin
            errors++; $display("FAIL rst_mid_flush: got %b want %b", o, e);
        end
        rst = 1'b0;
        tick(o, e);
        checks++;
        if (o !== e || o[12] !== 1'b1 || o[10] !== 1'b0 || o[3:0] !== 4'd0) begin
            errors++; $display("FAIL post_rst_run: got %b want %b", o, e);
        end
    endtask

    task automatic test_saturation();
        logic [12:0] o, e;
        doReset();
        mem_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(o, e);
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL sat_cycle%0d: got %b want %b", i, o, e);
            end
        end
        mem_busy = 1'b0;
        tick(o, e);
        checks++;
        if (o !== e || o[3:0] !== 4'hF) begin
            errors++; $display("FAIL sat_value: got %b want %b", o, e);
        end
    endtask

    task automatic test_random();
        logic [12:0] o, e;
        doReset();
        for (int i = 0; i < 1500; i++) begin
            rst              = ($urandom_range(0, 49) == 0);
            id_rs            = 5'($urandom_range(0, 3));
            id_rt            = 5'($urandom_range(0, 3));
            id_uses_rt       = 1'($urandom);
            id_ex_mem_read   = ($urandom_range(0, 2) == 0);
            id_ex_rs         = 5'($urandom_range(0, 3));
            id_ex_rt         = 5'($urandom_range(0, 3));
            ex_mem_reg_write = 1'($urandom);
            ex_mem_rd        = 5'($urandom_range(0, 3));
            mem_wb_reg_write = 1'($urandom);
            mem_wb_rd        = 5'($urandom_range(0, 3));
            branch_taken     = ($urandom_range(0, 5) == 0);
            jump             = ($urandom_range(0, 11) == 0);
            mem_busy         = ($urandom_range(0, 7) == 0);
            tick(o, e);
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL random_cycle%0d: got %b want %b", i, o, e);
            end
        end
    endtask

    initial begin
        idle();
        #1;
        test_reset();
        test_forwarding();
        test_load_stall();
        test_flush();
        test_mem_wait();
        test_reset_mid_flush();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
